// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the I/D memory-port arbiter: FSM state encoding,
// requester identifiers, captured operation kind, and a small helper
// that returns the opposite requester (used for round-robin ties).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // The requester that was not the argument.
  function automatic arb_src_t other_src(input arb_src_t src);
    arb_src_t result;
    case (src)
      SRC_I:   result = SRC_D;
      SRC_D:   result = SRC_I;
      default: result = SRC_D;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch-side (i_*), data-side (d_*) and downstream (mem_*)
// signals of the arbiter.
//   slave  : the arbiter's view (consumes requests, drives mem_* and resp)
//   master : the core + memory view (drives requests and mem_resp/rdata)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [BE_WIDTH-1:0]   d_byte_enable;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [BE_WIDTH-1:0]   mem_byte_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/arb_req_reg.sv
// arb_req_reg
// Capture register for the granted request: address, store data, byte
// mask and operation. Loads on `load`, clears to zero on `clear`
// (synchronous), otherwise holds so the downstream port stays stable for
// the whole memory transaction.
// Ports: clk, clear, load, *_in (next request), *_r (captured request).
module arb_req_reg
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    load,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic [DATA_WIDTH/8-1:0] be_in,
  input  arb_op_t                 op_in,
  output logic [ADDR_WIDTH-1:0]   addr_r,
  output logic [DATA_WIDTH-1:0]   wdata_r,
  output logic [DATA_WIDTH/8-1:0] be_r,
  output arb_op_t                 op_r
);

  // Request capture: clear wins over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
      be_r    <= {(DATA_WIDTH/8){1'b0}};
      op_r    <= OP_READ;
    end else if (load) begin
      addr_r  <= addr_in;
      wdata_r <= wdata_in;
      be_r    <= be_in;
      op_r    <= op_in;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one downstream memory port between the instruction-fetch and
// data sides of the core. A granted request is captured into arb_req_reg
// and driven on mem_* until mem_resp; the response pulse is routed to the
// owner. On completion the other requester, if pending, is granted
// directly without an idle cycle.
// Ports: clk, rst (synchronous, active-high), bus (mem_port_arbiter_if.slave).
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN -- when defined, IDLE ties go
// to the requester not served last; otherwise ties always go to D.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

  arb_state_t            state_r;
  arb_state_t            next_state_s;
  logic                  load_s;
  arb_src_t              load_src_s;
  arb_src_t              tie_src_s;
  logic                  i_pend_s;
  logic                  d_pend_s;

  logic [ADDR_WIDTH-1:0] cap_addr_s;
  logic [DATA_WIDTH-1:0] cap_wdata_s;
  logic [BE_WIDTH-1:0]   cap_be_s;
  arb_op_t               cap_op_s;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [BE_WIDTH-1:0]   be_r;
  arb_op_t               op_r;

  assign i_pend_s = bus.i_read;
  assign d_pend_s = bus.d_read | bus.d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_src_t last_src_r;

  // Last-served flag: records the owner of every completed transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_src_r <= SRC_I;
    end else if ((state_r == SERVE_I) && bus.mem_resp) begin
      last_src_r <= SRC_I;
    end else if ((state_r == SERVE_D) && bus.mem_resp) begin
      last_src_r <= SRC_D;
    end
  end

  assign tie_src_s = other_src(last_src_r);
`else
  assign tie_src_s = SRC_D;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and grant selection. While serving, only the other side
  // is eligible on completion: the served side still holds its (now
  // stale) request during the response cycle.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    load_src_s   = SRC_I;
    case (state_r)
      IDLE: begin
        if (i_pend_s && d_pend_s) begin
          load_s       = 1'b1;
          load_src_s   = tie_src_s;
          next_state_s = (tie_src_s == SRC_I) ? SERVE_I : SERVE_D;
        end else if (d_pend_s) begin
          load_s       = 1'b1;
          load_src_s   = SRC_D;
          next_state_s = SERVE_D;
        end else if (i_pend_s) begin
          load_s       = 1'b1;
          load_src_s   = SRC_I;
          next_state_s = SERVE_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp && d_pend_s) begin
          load_s       = 1'b1;
          load_src_s   = SRC_D;
          next_state_s = SERVE_D;
        end else if (bus.mem_resp) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp && i_pend_s) begin
          load_s       = 1'b1;
          load_src_s   = SRC_I;
          next_state_s = SERVE_I;
        end else if (bus.mem_resp) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SERVE_D;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Capture mux: a fetch is always a full-word read; a data access is a
  // write whenever d_write is high, regardless of d_read.
  always_comb begin
    cap_addr_s  = bus.i_address;
    cap_wdata_s = {DATA_WIDTH{1'b0}};
    cap_be_s    = {BE_WIDTH{1'b1}};
    cap_op_s    = OP_READ;
    if (load_src_s == SRC_D) begin
      cap_addr_s  = bus.d_address;
      cap_wdata_s = bus.d_wdata;
      cap_be_s    = bus.d_byte_enable;
      cap_op_s    = bus.d_write ? OP_WRITE : OP_READ;
    end else begin
      cap_addr_s  = bus.i_address;
      cap_wdata_s = {DATA_WIDTH{1'b0}};
      cap_be_s    = {BE_WIDTH{1'b1}};
      cap_op_s    = OP_READ;
    end
  end

  arb_req_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_req_reg (
    .clk      (clk),
    .clear    (rst),
    .load     (load_s),
    .addr_in  (cap_addr_s),
    .wdata_in (cap_wdata_s),
    .be_in    (cap_be_s),
    .op_in    (cap_op_s),
    .addr_r   (addr_r),
    .wdata_r  (wdata_r),
    .be_r     (be_r),
    .op_r     (op_r)
  );

  // Output decode: downstream strobes come from state and captured op
  // only; resp pulses are the live mem_resp gated by ownership.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    case (state_r)
      SERVE_I: begin
        bus.mem_read  = (op_r == OP_READ);
        bus.mem_write = (op_r == OP_WRITE);
        bus.i_resp    = bus.mem_resp;
      end
      SERVE_D: begin
        bus.mem_read  = (op_r == OP_READ);
        bus.mem_write = (op_r == OP_WRITE);
        bus.d_resp    = bus.mem_resp;
      end
      IDLE: begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
      default: begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
    endcase
  end

  assign bus.mem_address     = addr_r & ALIGN_MASK;
  assign bus.mem_wdata       = wdata_r;
  assign bus.mem_byte_enable = be_r;
  assign bus.i_rdata         = bus.mem_rdata;
  assign bus.d_rdata         = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic, all checked each
// cycle against a transaction-level model of who owns the port and what
// request it captured.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: owner 0 = nobody, 1 = fetch side, 2 = data side.
  int          m_owner  = 0;
  logic [31:0] m_addr   = 32'd0;
  logic [31:0] m_wdata  = 32'd0;
  logic [3:0]  m_be     = 4'd0;
  logic        m_wr     = 1'b0;
  logic        m_last_i = 1'b1;
  logic        m_fresh  = 1'b1;
  logic        exp_i_resp = 1'b0;
  logic        exp_d_resp = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner  = 0;
    m_addr   = 32'd0;
    m_wdata  = 32'd0;
    m_be     = 4'd0;
    m_wr     = 1'b0;
    m_last_i = 1'b1;
    m_fresh  = 1'b1;
  endfunction

  function automatic void grab(input int who);
    m_owner = who;
    m_fresh = 1'b0;
    if (who == 1) begin
      m_addr  = bus.i_address;
      m_wdata = 32'd0;
      m_be    = 4'hF;
      m_wr    = 1'b0;
    end else begin
      m_addr  = bus.d_address;
      m_wdata = bus.d_wdata;
      m_be    = bus.d_byte_enable;
      m_wr    = bus.d_write;
    end
  endfunction

  function automatic int tie_pick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return m_last_i ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  // One clock: check outputs, take the edge, advance the model.
  task automatic cycle();
    logic i_p;
    logic d_p;
    #1;
    exp_i_resp = (m_owner == 1) && bus.mem_resp;
    exp_d_resp = (m_owner == 2) && bus.mem_resp;
    check_val("mem_read",  32'(bus.mem_read),  32'((m_owner != 0) && !m_wr));
    check_val("mem_write", 32'(bus.mem_write), 32'((m_owner != 0) && m_wr));
    check_val("i_resp",    32'(bus.i_resp),    32'(exp_i_resp));
    check_val("d_resp",    32'(bus.d_resp),    32'(exp_d_resp));
    check_val("i_rdata",   bus.i_rdata,        bus.mem_rdata);
    check_val("d_rdata",   bus.d_rdata,        bus.mem_rdata);
    if ((m_owner != 0) || m_fresh) begin
      check_val("mem_address", bus.mem_address, {m_addr[31:2], 2'b00});
      check_val("mem_wdata",   bus.mem_wdata,   m_wdata);
      check_val("mem_be",      32'(bus.mem_byte_enable), 32'(m_be));
    end
    @(posedge clk);
    i_p = bus.i_read;
    d_p = bus.d_read | bus.d_write;
    if (rst) begin
      model_reset();
    end else begin
      case (m_owner)
        0: begin
          if (i_p && d_p) grab(tie_pick());
          else if (d_p)   grab(2);
          else if (i_p)   grab(1);
        end
        1: if (bus.mem_resp) begin
          m_last_i = 1'b1;
          if (d_p) grab(2); else m_owner = 0;
        end
        2: if (bus.mem_resp) begin
          m_last_i = 1'b0;
          if (i_p) grab(1); else m_owner = 0;
        end
        default: m_owner = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_read        = 1'b0;
    bus.i_address     = 32'd0;
    bus.d_read        = 1'b0;
    bus.d_write       = 1'b0;
    bus.d_byte_enable = 4'd0;
    bus.d_address     = 32'd0;
    bus.d_wdata       = 32'd0;
    bus.mem_resp      = 1'b0;
    bus.mem_rdata     = 32'd0;
  endtask

  logic i_busy;
  logic d_busy;
  int   wait_cnt;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // Fetch only, 1-cycle memory.
    bus.i_read = 1'b1; bus.i_address = 32'h60;
    cycle();
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    #1;
    check_val("ionly_mem_read", 32'(bus.mem_read), 32'd1);
    check_val("ionly_addr",     bus.mem_address,   32'h60);
    check_val("ionly_resp",     32'(bus.i_resp),   32'd1);
    check_val("ionly_rdata",    bus.i_rdata,       32'hCAFE_0001);
    cycle();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0;
    #1;
    check_val("ionly_drop", 32'(bus.mem_read), 32'd0);
    cycle();

    // Tie with I served last: D first, then I back-to-back.
    bus.i_read = 1'b1; bus.i_address = 32'h200;
    bus.d_read = 1'b1; bus.d_address = 32'h304;
    cycle();
    bus.mem_resp = 1'b1;
    #1;
    check_val("tie1_d_first", 32'(bus.d_resp), 32'd1);
    check_val("tie1_i_wait",  32'(bus.i_resp), 32'd0);
    cycle();
    bus.d_read = 1'b0;
    #1;
    check_val("tie1_i_b2b_read", 32'(bus.mem_read), 32'd1);
    check_val("tie1_i_b2b_addr", bus.mem_address,   32'h200);
    check_val("tie1_i_resp",     32'(bus.i_resp),   32'd1);
    cycle();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0;
    cycle();

    // Store with unaligned address.
    bus.d_write = 1'b1; bus.d_address = 32'h1003;
    bus.d_byte_enable = 4'h8; bus.d_wdata = 32'hAB00_0000;
    cycle();
    bus.mem_resp = 1'b1;
    #1;
    check_val("st_write", 32'(bus.mem_write), 32'd1);
    check_val("st_addr",  bus.mem_address,    32'h1000);
    check_val("st_be",    32'(bus.mem_byte_enable), 32'h8);
    check_val("st_wdata", bus.mem_wdata,      32'hAB00_0000);
    check_val("st_resp",  32'(bus.d_resp),    32'd1);
    cycle();
    bus.d_write = 1'b0; bus.mem_resp = 1'b0;
    cycle();

    // Second tie, D served last.
    bus.i_read = 1'b1; bus.i_address = 32'h240;
    bus.d_read = 1'b1; bus.d_address = 32'h340;
    cycle();
    bus.mem_resp = 1'b1;
    #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check_val("tie2_rr_i", 32'(bus.i_resp), 32'd1);
    cycle();
    bus.i_read = 1'b0;
`else
    check_val("tie2_fixed_d", 32'(bus.d_resp), 32'd1);
    cycle();
    bus.d_read = 1'b0;
`endif
    cycle();
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.mem_resp = 1'b0;
    cycle();

    // Requester address changes during a 3-cycle memory wait.
    bus.i_read = 1'b1; bus.i_address = 32'h40;
    cycle();
    bus.i_address = 32'h80;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("hold_addr", bus.mem_address, 32'h40);
      cycle();
    end
    bus.mem_resp = 1'b1;
    #1;
    check_val("hold_addr_resp", bus.mem_address, 32'h40);
    check_val("hold_i_resp",    32'(bus.i_resp), 32'd1);
    cycle();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0;
    cycle();

    // Stray mem_resp in IDLE.
    bus.mem_resp = 1'b1;
    #1;
    check_val("stray_i_resp", 32'(bus.i_resp), 32'd0);
    check_val("stray_d_resp", 32'(bus.d_resp), 32'd0);
    cycle();
    bus.mem_resp = 1'b0;
    #1;
    check_val("stray_idle", 32'(bus.mem_read | bus.mem_write), 32'd0);
    cycle();

    // Reset while serving D, then a normal fetch.
    bus.d_read = 1'b1; bus.d_address = 32'h500;
    cycle();
    #1;
    check_val("rst_serving_d", 32'(bus.mem_read), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0; bus.d_read = 1'b0; bus.mem_resp = 1'b1;
    #1;
    check_val("rst_mem_read",  32'(bus.mem_read),  32'd0);
    check_val("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check_val("rst_addr",      bus.mem_address,    32'd0);
    check_val("rst_wdata",     bus.mem_wdata,      32'd0);
    check_val("rst_be",        32'(bus.mem_byte_enable), 32'd0);
    check_val("rst_d_resp",    32'(bus.d_resp),    32'd0);
    cycle();
    bus.mem_resp = 1'b0;
    bus.i_read = 1'b1; bus.i_address = 32'h700;
    cycle();
    bus.mem_resp = 1'b1;
    #1;
    check_val("post_rst_i_resp", 32'(bus.i_resp), 32'd1);
    cycle();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0;
    cycle();

    // Randomized traffic.
    i_busy = 1'b0; d_busy = 1'b0; wait_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (exp_i_resp) i_busy = 1'b0;
      if (exp_d_resp) d_busy = 1'b0;
      rst = ($urandom_range(0, 499) == 0);
      if (rst) begin
        i_busy = 1'b0; d_busy = 1'b0;
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      end else begin
        if (!i_busy) begin
          i_busy = ($urandom_range(0, 1) == 1);
          bus.i_read = i_busy;
          bus.i_address = $urandom;
        end else if ((m_owner == 1) && ($urandom_range(0, 3) == 0)) begin
          bus.i_address = $urandom;
        end
        if (!d_busy) begin
          d_busy = ($urandom_range(0, 1) == 1);
          bus.d_write = d_busy && ($urandom_range(0, 1) == 1);
          bus.d_read = d_busy && (!bus.d_write || ($urandom_range(0, 1) == 1));
          bus.d_address = $urandom;
          bus.d_wdata = $urandom;
          bus.d_byte_enable = 4'($urandom_range(0, 15));
        end else if ((m_owner == 2) && ($urandom_range(0, 3) == 0)) begin
          bus.d_address = $urandom;
          bus.d_wdata = $urandom;
        end
      end
      if (m_owner != 0) begin
        wait_cnt++;
        bus.mem_resp = (wait_cnt >= 4) || ($urandom_range(0, 1) == 1);
        if (bus.mem_resp) wait_cnt = 0;
      end else begin
        wait_cnt = 0;
        bus.mem_resp = ($urandom_range(0, 7) == 0);
      end
      bus.mem_rdata = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
